// File: rtl/cdbus_rx_drain_if.sv
// CDBUS CSR master bus plus the outgoing frame byte stream of the receive drain.
// Stream: a byte moves on a rising edge where m_valid && m_ready; while m_valid is high and m_ready low, m_data/m_first/m_last hold.
interface cdbus_rx_drain_if;
    logic [4:0] csr_address;
    logic       csr_read;
    logic [7:0] csr_readdata;
    logic       csr_write;
    logic [7:0] csr_writedata;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_first;
    logic       m_last;

    modport master (
        output csr_address, csr_read, csr_write, csr_writedata,
        output m_data, m_valid, m_first, m_last,
        input  csr_readdata, m_ready
    );

    modport slave (
        input  csr_address, csr_read, csr_write, csr_writedata,
        input  m_data, m_valid, m_first, m_last,
        output csr_readdata, m_ready
    );
endinterface

// File: rtl/cdbus_rx_drain.sv
// Polls a CDBUS controller for received pages, streams each frame out byte by byte,
// drops frames with an oversized length byte and releases the page when done.
module cdbus_rx_drain #(
    parameter int POLL_GAP = 16,
    parameter int MAX_LEN  = 253
) (
    input  logic                  clk,
    input  logic                  reset,
    cdbus_rx_drain_if.master      bus,
    input  logic                  flush,
    output logic                  frame_err,
    output logic [7:0]            frame_cnt,
    output logic [2:0]            state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_HDR, S_DATA, S_RELEASE, S_FLUSH
    } state_t;

    localparam logic [7:0] GAP_LAST  = 8'(POLL_GAP - 1);
    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    state_t     state;
    logic [7:0] gap_cnt;
    logic [2:0] hdr_idx;
    logic [7:0] src_q, dst_q, len_q, remaining;
    logic       drop_q;
    logic [7:0] m_data_q;
    logic       m_valid_q, m_first_q, m_last_q;
    logic       can_load;
    logic       rd_go, wr_go;
    logic [4:0] addr;
    logic [7:0] wdata;

    assign can_load  = !m_valid_q || bus.m_ready;
    assign state_dbg = state;

    // CSR strobes are decoded from the registered state so a byte read can
    // follow m_ready in the same cycle; flush aborts any access immediately.
    always_comb begin
        rd_go = 1'b0;
        wr_go = 1'b0;
        addr  = 5'h00;
        wdata = 8'h00;
        if (!flush) begin
            case (state)
                S_POLL: begin
                    rd_go = 1'b1;
                    addr  = 5'h09;
                end
                S_HDR: begin
                    if (hdr_idx < 3'd3 && can_load) begin
                        rd_go = 1'b1;
                        addr  = 5'h0b;
                    end
                end
                S_DATA: begin
                    if (can_load) begin
                        rd_go = 1'b1;
                        addr  = 5'h0b;
                    end
                end
                S_RELEASE: begin
                    if (can_load) begin
                        wr_go = 1'b1;
                        addr  = 5'h0d;
                        wdata = 8'h02;
                    end
                end
                S_FLUSH: begin
                    wr_go = 1'b1;
                    addr  = 5'h0d;
                    wdata = 8'h10;
                end
                default: ;
            endcase
        end
    end

    assign bus.csr_read      = rd_go;
    assign bus.csr_write     = wr_go;
    assign bus.csr_address   = addr;
    assign bus.csr_writedata = wdata;
    assign bus.m_data        = m_data_q;
    assign bus.m_valid       = m_valid_q;
    assign bus.m_first       = m_first_q;
    assign bus.m_last        = m_last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            gap_cnt   <= 8'd0;
            hdr_idx   <= 3'd0;
            src_q     <= 8'd0;
            dst_q     <= 8'd0;
            len_q     <= 8'd0;
            remaining <= 8'd0;
            drop_q    <= 1'b0;
            m_data_q  <= 8'd0;
            m_valid_q <= 1'b0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            frame_err <= 1'b0;
            if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;
            if (flush) begin
                state     <= S_FLUSH;
                m_valid_q <= 1'b0;
                drop_q    <= 1'b0;
                gap_cnt   <= 8'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= 8'd0;
                            state   <= S_POLL;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    S_POLL: begin
                        hdr_idx <= 3'd0;
                        state   <= bus.csr_readdata[1] ? S_HDR : S_IDLE;
                    end
                    // Header bytes are buffered until the length byte is known,
                    // so a dropped frame never shows up on the stream.
                    S_HDR: begin
                        if (can_load) begin
                            hdr_idx <= hdr_idx + 3'd1;
                            case (hdr_idx)
                                3'd0: src_q <= bus.csr_readdata;
                                3'd1: dst_q <= bus.csr_readdata;
                                3'd2: begin
                                    len_q <= bus.csr_readdata;
                                    if ({1'b0, bus.csr_readdata} > MAX_LEN_W) begin
                                        frame_err <= 1'b1;
                                        drop_q    <= 1'b1;
                                        state     <= S_RELEASE;
                                    end
                                end
                                3'd3: begin
                                    m_data_q  <= src_q;
                                    m_valid_q <= 1'b1;
                                    m_first_q <= 1'b1;
                                    m_last_q  <= 1'b0;
                                end
                                3'd4: begin
                                    m_data_q  <= dst_q;
                                    m_valid_q <= 1'b1;
                                    m_first_q <= 1'b0;
                                    m_last_q  <= 1'b0;
                                end
                                default: begin
                                    m_data_q  <= len_q;
                                    m_valid_q <= 1'b1;
                                    m_first_q <= 1'b0;
                                    m_last_q  <= (len_q == 8'd0);
                                    remaining <= len_q;
                                    state     <= (len_q == 8'd0) ? S_RELEASE : S_DATA;
                                end
                            endcase
                        end
                    end
                    S_DATA: begin
                        if (can_load) begin
                            m_data_q  <= bus.csr_readdata;
                            m_valid_q <= 1'b1;
                            m_first_q <= 1'b0;
                            m_last_q  <= (remaining == 8'd1);
                            remaining <= remaining - 8'd1;
                            if (remaining == 8'd1) state <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        if (can_load) begin
                            if (!drop_q) frame_cnt <= frame_cnt + 8'd1;
                            drop_q <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                    S_FLUSH: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
